// File: rtl/lift_call_scheduler.sv
// Upstream request stage for the 4-floor lift controller: latches calls, serves them one at a
// time in SCAN order, detects arrival from the controller state and holds the door for a dwell.
module lift_call_scheduler #(
  parameter int unsigned DWELL     = 4,
  parameter int unsigned HOME_IDLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call,
  input  logic [1:0] lift_state,
  output logic [1:0] req_floor,
  output logic [3:0] pending,
  output logic [3:0] served,
  output logic       door_open,
  output logic       busy
);

  typedef enum logic [1:0] {
    StIdle,
    StTravel,
    StDwell
  } state_e;

  state_e     state_q;
  logic [1:0] pos_q;
  logic       dir_q;  // 0 = up, 1 = down
  logic [3:0] cnt_q;

  logic       up_found, dn_found;
  logic [1:0] up_floor, dn_floor;
  logic [1:0] target;
  logic       target_dir;
  logic [3:0] cnt_inc;
  logic       lift_idle;
  logic       arrive;
  logic       dwell_done;
  logic       home_due;
  logic [3:0] clear;

  // Nearest pending floor strictly above and strictly below the believed car position.
  always_comb begin
    up_found = 1'b0;
    up_floor = pos_q;
    dn_found = 1'b0;
    dn_floor = pos_q;
    for (int f = 3; f >= 0; f--) begin
      if (2'(f) > pos_q && pending[2'(f)]) begin
        up_found = 1'b1;
        up_floor = 2'(f);
      end
    end
    for (int f = 0; f < 4; f++) begin
      if (2'(f) < pos_q && pending[2'(f)]) begin
        dn_found = 1'b1;
        dn_floor = 2'(f);
      end
    end
  end

  // SCAN choice: current floor first, then keep direction, else reverse.
  always_comb begin
    target     = pos_q;
    target_dir = dir_q;
    if (!pending[pos_q]) begin
      if (dir_q == 1'b0) begin
        if (up_found) begin
          target = up_floor;
        end else begin
          target     = dn_floor;
          target_dir = 1'b1;
        end
      end else begin
        if (dn_found) begin
          target = dn_floor;
        end else begin
          target     = up_floor;
          target_dir = 1'b0;
        end
      end
    end
  end

  always_comb begin
    cnt_inc    = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;
    lift_idle  = (lift_state == 2'b00) || (lift_state == 2'b11);
    // Two controller sampling edges must pass before an idle state counts as arrival.
    arrive     = (state_q == StTravel) && lift_idle && (cnt_q >= 4'd2);
    dwell_done = 32'(cnt_q) >= DWELL - 32'd1;
    home_due   = 32'(cnt_q) >= HOME_IDLE - 32'd1;
  end

  // Bit retired this edge; repeat calls for the open-door floor are swallowed during dwell.
  always_comb begin
    clear = 4'b0000;
    if (arrive) begin
      clear = 4'b0001 << req_floor;
    end else if (state_q == StDwell) begin
      clear = 4'b0001 << pos_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pos_q     <= 2'd0;
      dir_q     <= 1'b0;
      cnt_q     <= 4'd0;
      req_floor <= 2'd0;
      pending   <= 4'b0000;
      served    <= 4'b0000;
      door_open <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pending <= (pending | call) & ~clear;
      served  <= 4'b0000;
      case (state_q)
        StIdle: begin
          if (pending != 4'b0000) begin
            req_floor <= target;
            dir_q     <= target_dir;
            cnt_q     <= 4'd0;
            busy      <= 1'b1;
            state_q   <= StTravel;
          end else if (call != 4'b0000) begin
            cnt_q <= 4'd0;
          end else if (home_due && pos_q != 2'd0) begin
            pos_q     <= 2'd0;
            req_floor <= 2'd0;
            dir_q     <= 1'b0;
            cnt_q     <= 4'd0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StTravel: begin
          if (arrive) begin
            pos_q     <= req_floor;
            served    <= 4'b0001 << req_floor;
            door_open <= 1'b1;
            cnt_q     <= 4'd0;
            state_q   <= StDwell;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StDwell: begin
          if (dwell_done) begin
            door_open <= 1'b0;
            busy      <= 1'b0;
            cnt_q     <= 4'd0;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Scoreboard bench for lift_call_scheduler: a timeline reference model predicts outputs and
// served events; a negedge monitor compares them against the DUT with a simple lift controller.
module tb_lift_call_scheduler;

  localparam int unsigned DWELL     = 4;
  localparam int unsigned HOME_IDLE = 4;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic [3:0] call       = 4'b0000;
  logic [1:0] lift_state = 2'b00;
  logic [1:0] req_floor;
  logic [3:0] pending;
  logic [3:0] served;
  logic       door_open;
  logic       busy;

  lift_call_scheduler #(
    .DWELL    (DWELL),
    .HOME_IDLE(HOME_IDLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .call      (call),
    .lift_state(lift_state),
    .req_floor (req_floor),
    .pending   (pending),
    .served    (served),
    .door_open (door_open),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Lift controller: one floor per edge toward req_floor; optionally random state reports.
  int cfloor  = 0;
  bit rand_ls = 1'b0;
  always @(posedge clk) begin
    if (rand_ls) begin
      lift_state <= 2'($urandom_range(0, 3));
    end else if (lift_state == 2'b10 || lift_state == 2'b01) begin
      if (cfloor < int'(req_floor)) begin
        cfloor     <= cfloor + 1;
        lift_state <= (cfloor + 1 == int'(req_floor)) ? 2'b00 : 2'b10;
      end else if (cfloor > int'(req_floor)) begin
        cfloor     <= cfloor - 1;
        lift_state <= (cfloor - 1 == int'(req_floor)) ? 2'b00 : 2'b01;
      end else begin
        lift_state <= 2'b00;
      end
    end else if (int'(req_floor) > cfloor) begin
      lift_state <= 2'b10;
    end else if (int'(req_floor) < cfloor) begin
      lift_state <= 2'b01;
    end else begin
      lift_state <= 2'b00;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  oh;
    int unsigned at;
  } ev_t;
  ev_t sbq[$];

  // Reference model state and its predicted outputs
  logic [3:0] mpend;
  int         mpos;
  int         mdir;
  logic [1:0] exp_req;
  logic [3:0] exp_pend;
  logic       exp_door;
  logic       exp_busy;
  logic [3:0] s_call;
  logic [1:0] s_ls;
  logic       s_rst;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b want %b at edge %0d", name, got, want, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    s_call = call;
    s_ls   = lift_state;
    s_rst  = reset;
  endtask

  // Nearest pending floor by SCAN: own floor, then onward in mdir, else the other way.
  task automatic pick(output int tgt);
    tgt = mpos;
    if (mpend[mpos]) return;
    repeat (2) begin
      if (mdir == 0) begin
        for (int f = mpos + 1; f <= 3; f++) if (mpend[f]) begin tgt = f; return; end
      end else begin
        for (int f = mpos - 1; f >= 0; f--) if (mpend[f]) begin tgt = f; return; end
      end
      mdir = 1 - mdir;
    end
  endtask

  task automatic run_model();
    int tgt;
    int tc;
    int idle_n;
    idle_n = 0;
    forever begin
      while (mpend == 4'b0000) begin
        tick();
        if (s_rst) return;
        mpend = mpend | s_call;
        if (s_call != 4'b0000) begin
          idle_n = 0;
        end else begin
          idle_n++;
          if (idle_n >= int'(HOME_IDLE) && mpos != 0) begin
            mpos   = 0;
            mdir   = 0;
            idle_n = 0;
          end
        end
        exp_req  = 2'(mpos);
        exp_pend = mpend;
      end
      pick(tgt);
      tick();
      if (s_rst) return;
      mpend    = mpend | s_call;
      exp_req  = 2'(tgt);
      exp_busy = 1'b1;
      exp_pend = mpend;
      tc = 0;
      forever begin
        tick();
        if (s_rst) return;
        if (tc >= 2 && (s_ls == 2'b00 || s_ls == 2'b11)) break;
        mpend    = mpend | s_call;
        exp_pend = mpend;
        tc++;
      end
      mpend = (mpend | s_call) & ~4'(1 << tgt);
      mpos  = tgt;
      sbq.push_back('{oh: 4'(1 << tgt), at: edge_n + 1});
      exp_door = 1'b1;
      exp_pend = mpend;
      repeat (DWELL) begin
        tick();
        if (s_rst) return;
        mpend    = (mpend | s_call) & ~4'(1 << mpos);
        exp_pend = mpend;
      end
      exp_door = 1'b0;
      exp_busy = 1'b0;
      idle_n   = 0;
    end
  endtask

  initial begin
    forever begin
      mpend    = 4'b0000;
      mpos     = 0;
      mdir     = 0;
      exp_req  = 2'd0;
      exp_pend = 4'b0000;
      exp_door = 1'b0;
      exp_busy = 1'b0;
      run_model();
    end
  end

  // Monitor: per-cycle output compare plus served-event scoreboard
  always @(negedge clk) begin
    chk("pending", pending, exp_pend);
    chk("req_floor", {2'b00, req_floor}, {2'b00, exp_req});
    chk("door_open", {3'b000, door_open}, {3'b000, exp_door});
    chk("busy", {3'b000, busy}, {3'b000, exp_busy});
    while (sbq.size() > 0 && sbq[0].at < edge_n) begin
      n_cmp++;
      n_err++;
      $display("FAIL served_missing: got no pulse want %b at edge %0d", sbq[0].oh, sbq[0].at);
      void'(sbq.pop_front());
    end
    if (served !== 4'b0000) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL served_unexpected: got %b want 0000 at edge %0d", served, edge_n);
      end else begin
        ev_t e;
        e = sbq.pop_front();
        chk("served", served, e.oh);
        n_cmp++;
        if (e.at != edge_n) begin
          n_err++;
          $display("FAIL served_edge: got edge %0d want edge %0d", edge_n, e.at);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] c);
    call = c;
    @(negedge clk);
    call = 4'b0000;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(busy === 1'b0 && pending === 4'b0000)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        n_cmp++;
        n_err++;
        $display("FAIL wait_idle: got busy=%b pending=%b want idle within %0d cycles",
                 busy, pending, budget);
        return;
      end
    end
  endtask

  task automatic wait_door(input int budget);
    int n;
    n = 0;
    while (door_open !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        n_cmp++;
        n_err++;
        $display("FAIL wait_door: got door_open=%b want 1 within %0d cycles", door_open, budget);
        return;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);

    // Single call to floor 2 from reset
    pulse(4'b0100);
    wait_idle(60);

    // Same-floor call, then repeats during the dwell
    pulse(4'b0100);
    wait_door(30);
    pulse(4'b0100);
    cycles(1);
    pulse(4'b0100);
    wait_idle(60);

    // Home to floor 0, go to floor 1, then SCAN 3 before 0
    cycles(10);
    pulse(4'b0010);
    wait_door(40);
    pulse(4'b1001);
    wait_idle(120);

    // Homing cancelled by a call after 3 idle cycles
    pulse(4'b1000);
    wait_idle(60);
    cycles(3);
    pulse(4'b0001);
    wait_idle(60);

    // Retiring-floor call held across arrival, plus a new call during travel
    pulse(4'b1000);
    cycles(2);
    call = 4'b1010;
    cycles(8);
    call = 4'b0000;
    wait_idle(120);

    // Reset in the middle of a travel
    pulse(4'b1010);
    cycles(3);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(6);

    // Random calls, a window of erratic controller states, and one late reset
    for (int i = 0; i < 500; i++) begin
      rand_ls = (i >= 200 && i < 300);
      call    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      if (i == 400) reset = 1'b1;
      if (i == 402) reset = 1'b0;
      @(negedge clk);
    end
    call    = 4'b0000;
    rand_ls = 1'b0;
    wait_idle(300);
    cycles(10);

    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL served_drain: got %0d outstanding events want 0", sbq.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
